gray_world_balance: RTL and testbench

- Streaming gray-world automatic white-balance stage on a 24-bit RGB AXI4-Stream video path, with no back-pressure.
- Accumulates per-channel sums over each frame and computes fixed-point channel gains during blanking.
- Applies the gains from the previous complete frame to every pixel of the next frame.
- Sits between the frame source (pixel generator / camera front end) and downstream video sinks.

---
 rtl/gray_world_balance.sv | 264 ++++++++++++++++++++++++++
 tb/tb_gray_world_balance.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_world_balance.sv
// Gray-world automatic white balance on a 24-bit RGB AXI4-Stream path.
// Per-frame channel sums feed a shared restoring divider that produces Q8.8
// gains during blanking; each frame is scaled by the gains of the previous
// complete frame.
// Optional build macro: GW_UNITY_FIRST_FRAME_EN (gains reset to unity 256
// instead of 0, so the first frame after reset passes through unchanged).
module gray_world_balance #(
  parameter int unsigned NROWS = 550,
  parameter int unsigned NCOL  = 367
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [23:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [23:0] m_axis_tdata
);

  localparam int unsigned SW = $clog2(255 * NROWS * NCOL + 1);
  localparam int unsigned TW = SW + 2;
  localparam int unsigned NW = TW + 8;
  localparam int unsigned RW = $clog2(NROWS + 1);
  localparam int unsigned CW = $clog2(NW);

`ifdef GW_UNITY_FIRST_FRAME_EN
  localparam logic [15:0] GAIN_RST = 16'd256;
`else
  localparam logic [15:0] GAIN_RST = 16'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_STORE} state_t;

  state_t state, state_nx;

  logic [7:0]    px_r, px_g, px_b;
  logic          sof, eol, frame_done, start_c;
  logic [SW-1:0] sum_r, sum_g, sum_b;
  logic [SW-1:0] sum_r_nx, sum_g_nx, sum_b_nx;
  logic [SW-1:0] hold_r, hold_g, hold_b, hold_sel;
  logic [RW-1:0] row_cnt, row_eff;
  logic [TW-1:0] total;

  logic [1:0]    ch;
  logic [CW-1:0] bit_cnt;
  logic [NW-1:0] num, quo;
  logic [TW-1:0] den, rem, rem_nx;
  logic [TW:0]   rem_sh;
  logic          rem_ge;
  logic [15:0]   gain_q;
  logic          load_c, shift_c, store_c;

  logic [15:0]   gtmp_r, gtmp_g;
  logic [15:0]   pend_r, pend_g, pend_b;
  logic [15:0]   act_r, act_g, act_b;
  logic [15:0]   gsel_r, gsel_g, gsel_b;

  logic          v1, u1, l1;
  logic [23:0]   prod_r, prod_g, prod_b;

  function automatic logic [7:0] sat8(input logic [23:0] p);
    return (|p[23:16]) ? 8'hFF : p[15:8];
  endfunction

  assign px_r = s_axis_tdata[23:16];
  assign px_g = s_axis_tdata[15:8];
  assign px_b = s_axis_tdata[7:0];
  assign sof  = s_axis_tvalid & s_axis_tuser;
  assign eol  = s_axis_tvalid & s_axis_tlast;

  // Running sums including the current pixel; SOF restarts them
  always_comb begin
    sum_r_nx = sof ? SW'(px_r) : sum_r + SW'(px_r);
    sum_g_nx = sof ? SW'(px_g) : sum_g + SW'(px_g);
    sum_b_nx = sof ? SW'(px_b) : sum_b + SW'(px_b);
    row_eff  = s_axis_tuser ? '0 : row_cnt;
  end

  assign frame_done = eol && (row_eff == RW'(NROWS - 1));
  assign start_c    = frame_done && (state == S_IDLE);

  // Frame statistics and row counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= '0;
      sum_g   <= '0;
      sum_b   <= '0;
      row_cnt <= '0;
    end else if (s_axis_tvalid) begin
      sum_r <= sum_r_nx;
      sum_g <= sum_g_nx;
      sum_b <= sum_b_nx;
      if (eol && (row_eff < RW'(NROWS)))
        row_cnt <= row_eff + RW'(1);
      else
        row_cnt <= row_eff;
    end
  end

  // Snapshot of completed-frame sums; dropped while the divider is busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
      hold_g <= '0;
      hold_b <= '0;
    end else if (start_c) begin
      hold_r <= sum_r_nx;
      hold_g <= sum_g_nx;
      hold_b <= sum_b_nx;
    end
  end

  // Divider FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Divider FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_c) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_DIV;
      S_DIV:   if (bit_cnt == CW'(NW - 1)) state_nx = S_STORE;
      S_STORE: state_nx = (ch == 2'd2) ? S_IDLE : S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  // Divider FSM control strobes
  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    store_c = 1'b0;
    case (state)
      S_LOAD:  load_c  = 1'b1;
      S_DIV:   shift_c = 1'b1;
      S_STORE: store_c = 1'b1;
      default: ;
    endcase
  end

  // Operand selection, restoring step and gain clamping
  always_comb begin
    hold_sel = hold_r;
    if (ch == 2'd1) hold_sel = hold_g;
    if (ch == 2'd2) hold_sel = hold_b;
    total  = TW'(hold_r) + TW'(hold_g) + TW'(hold_b);
    rem_sh = {rem, num[NW-1]};
    rem_ge = rem_sh >= {1'b0, den};
    rem_nx = rem_ge ? TW'(rem_sh - {1'b0, den}) : TW'(rem_sh);
    if (den == '0)
      gain_q = 16'd256;
    else if ((quo >> 16) != '0)
      gain_q = 16'hFFFF;
    else
      gain_q = quo[15:0];
  end

  // Shared divider datapath and pending gains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch      <= '0;
      bit_cnt <= '0;
      num     <= '0;
      quo     <= '0;
      den     <= '0;
      rem     <= '0;
      gtmp_r  <= '0;
      gtmp_g  <= '0;
      pend_r  <= GAIN_RST;
      pend_g  <= GAIN_RST;
      pend_b  <= GAIN_RST;
    end else begin
      if (start_c) ch <= '0;
      if (load_c) begin
        num     <= {total, 8'd0};
        den     <= (TW'(hold_sel) << 1) + TW'(hold_sel);
        rem     <= '0;
        quo     <= '0;
        bit_cnt <= '0;
      end
      if (shift_c) begin
        rem     <= rem_nx;
        quo     <= {quo[NW-2:0], rem_ge};
        num     <= {num[NW-2:0], 1'b0};
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (store_c) begin
        case (ch)
          2'd0: gtmp_r <= gain_q;
          2'd1: gtmp_g <= gain_q;
          default: begin
            pend_r <= gtmp_r;
            pend_g <= gtmp_g;
            pend_b <= gain_q;
          end
        endcase
        ch <= ch + 2'd1;
      end
    end
  end

  // Gains for the SOF beat come straight from pending
  always_comb begin
    gsel_r = sof ? pend_r : act_r;
    gsel_g = sof ? pend_g : act_g;
    gsel_b = sof ? pend_b : act_b;
  end

  // Active gains latched at start of frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_r <= GAIN_RST;
      act_g <= GAIN_RST;
      act_b <= GAIN_RST;
    end else if (sof) begin
      act_r <= pend_r;
      act_g <= pend_g;
      act_b <= pend_b;
    end
  end

  // Stage 1: sideband delay and per-channel multiply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      u1     <= 1'b0;
      l1     <= 1'b0;
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
    end else begin
      v1 <= s_axis_tvalid;
      u1 <= s_axis_tuser;
      l1 <= s_axis_tlast;
      if (s_axis_tvalid) begin
        prod_r <= 24'(px_r) * 24'(gsel_r);
        prod_g <= 24'(px_g) * 24'(gsel_g);
        prod_b <= 24'(px_b) * 24'(gsel_b);
      end
    end
  end

  // Stage 2: scale back from Q8.8 with saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      m_axis_tvalid <= v1;
      m_axis_tuser  <= u1;
      m_axis_tlast  <= l1;
      if (v1) m_axis_tdata <= {sat8(prod_r), sat8(prod_g), sat8(prod_b)};
    end
  end

endmodule

// File: tb/tb_gray_world_balance.sv
// Scoreboard bench for gray_world_balance on a small 4x4 frame.
module tb_gray_world_balance;

  localparam int unsigned NROWS = 4;
  localparam int unsigned NCOL  = 4;

`ifdef GW_UNITY_FIRST_FRAME_EN
  localparam int RST_GAIN = 256;
`else
  localparam int RST_GAIN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [23:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [23:0] m_axis_tdata;

  typedef struct {
    int          cyc;
    logic        tuser;
    logic        tlast;
    logic [23:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   act[3];
  int   pend[3];

  gray_world_balance #(.NROWS(NROWS), .NCOL(NCOL)) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_gain(input longint sr, input longint sg, input longint sb,
                                    input longint sc);
    longint g;
    if (sc == 0) return 256;
    g = (256 * (sr + sg + sb)) / (3 * sc);
    return (g > 65535) ? 65535 : int'(g);
  endfunction

  function automatic logic [7:0] model_px(input logic [7:0] p, input int g);
    longint v;
    v = (longint'(p) * longint'(g)) >> 8;
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic drive(input logic v, input logic u, input logic l, input logic [23:0] d,
                       input logic [23:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    s_axis_tvalid = v;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tdata  = d;
    if (v) begin
      x.cyc   = cyc + 2;
      x.tuser = u;
      x.tlast = l;
      x.data  = e;
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'($urandom), 24'h0);
  endtask

  task automatic send_frame(input int nrows, input bit rnd, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input bit gaps);
    longint sr = 0, sg = 0, sb = 0;
    logic [7:0] pr, pg, pb;
    logic [23:0] e;
    for (int y = 0; y < nrows; y++) begin
      for (int x = 0; x < int'(NCOL); x++) begin
        if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
        pr = rnd ? 8'($urandom) : r;
        pg = rnd ? 8'($urandom) : g;
        pb = rnd ? 8'($urandom) : b;
        sr += pr;
        sg += pg;
        sb += pb;
        if (y == 0 && x == 0) act = pend;
        e = {model_px(pr, act[0]), model_px(pg, act[1]), model_px(pb, act[2])};
        drive(1'b1, (y == 0 && x == 0), (x == int'(NCOL) - 1), {pr, pg, pb}, e);
      end
    end
    if (nrows == int'(NROWS)) begin
      pend[0] = model_gain(sr, sg, sb, sr);
      pend[1] = model_gain(sr, sg, sb, sg);
      pend[2] = model_gain(sr, sg, sb, sb);
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    q.delete();
    @(negedge clk);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tuser"},  32'(m_axis_tuser),  32'd0);
    check({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    check({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act[i]  = RST_GAIN;
      pend[i] = RST_GAIN;
    end
  endtask

  // Output monitor: every cycle the DUT valid must match the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      exp_t x;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        x = q.pop_front();
        check("late_beat", 32'(cyc), 32'(x.cyc));
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        x = q.pop_front();
        check("tvalid", 32'(m_axis_tvalid), 32'd1);
        check("tuser",  32'(m_axis_tuser),  32'(x.tuser));
        check("tlast",  32'(m_axis_tlast),  32'(x.tlast));
        check("tdata",  32'(m_axis_tdata),  32'(x.data));
      end else begin
        check("tvalid_idle", 32'(m_axis_tvalid), 32'd0);
      end
    end
  end

  initial begin
    #2;
    do_reset("reset");
    idle(3);
    send_frame(NROWS, 0, 8'd100, 8'd100, 8'd100, 0);  // first frame: reset gains
    idle(100);
    send_frame(NROWS, 0, 8'd100, 8'd100, 8'd100, 0);  // neutral
    idle(100);
    send_frame(NROWS, 0, 8'd50, 8'd100, 8'd200, 0);   // colour cast stats
    idle(100);
    send_frame(NROWS, 0, 8'd50, 8'd100, 8'd200, 0);   // balanced to 116
    idle(100);
    send_frame(NROWS, 0, 8'd10, 8'd200, 8'd200, 0);   // large red gain
    idle(100);
    send_frame(NROWS, 0, 8'd255, 8'd200, 8'd200, 0);  // red saturates
    idle(100);
    send_frame(NROWS, 0, 8'd80, 8'd80, 8'd0, 0);      // zero blue channel
    idle(100);
    send_frame(NROWS, 0, 8'd80, 8'd80, 8'd0, 0);
    idle(100);
    send_frame(NROWS, 1, 8'd0, 8'd0, 8'd0, 1);        // random with valid gaps
    idle(100);
    send_frame(NROWS, 1, 8'd0, 8'd0, 8'd0, 1);
    idle(100);
    send_frame(2, 0, 8'd30, 8'd60, 8'd90, 0);         // truncated frame
    send_frame(NROWS, 1, 8'd0, 8'd0, 8'd0, 0);
    idle(100);
    send_frame(NROWS, 1, 8'd0, 8'd0, 8'd0, 0);
    idle(100);
    send_frame(NROWS, 0, 8'd50, 8'd100, 8'd200, 0);
    idle(100);
    send_frame(2, 0, 8'd50, 8'd100, 8'd200, 0);       // partial, then reset
    do_reset("midreset");
    send_frame(NROWS, 0, 8'd100, 8'd100, 8'd100, 0);
    idle(100);
    send_frame(NROWS, 0, 8'd100, 8'd100, 8'd100, 0);
    idle(10);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
